// File: rtl/hazard_controller_if.sv
// Pipeline hazard bus: ID/EX hazard fields and memory handshakes in, stage controls out.
// master = hazard_controller, slave = pipeline datapath.
interface hazard_controller_if;
  logic [2:0] id_SR1;
  logic [2:0] id_SR2;
  logic [2:0] id_DR;
  logic       id_uses_sr1;
  logic       id_uses_sr2;
  logic       id_is_store;
  logic       id_immsel;
  logic [2:0] ex_DR;
  logic       ex_regwrite;
  logic       ex_memread;
  logic       imem_read;
  logic       imem_resp;
  logic       dmem_req;
  logic       dmem_resp;
  logic       mem_br_taken;

  logic       pc_load;
  logic       if_id_load;
  logic       id_ex_load;
  logic       ex_mem_load;
  logic       mem_wb_load;
  logic       if_id_bubble;
  logic       id_ex_bubble;
  logic       ex_mem_bubble;
  logic       mem_wb_bubble;
  logic       pc_redirect;
  logic       forwarding_override;

  modport master (
    input  id_SR1, id_SR2, id_DR, id_uses_sr1, id_uses_sr2, id_is_store, id_immsel,
    input  ex_DR, ex_regwrite, ex_memread,
    input  imem_read, imem_resp, dmem_req, dmem_resp, mem_br_taken,
    output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
    output if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
    output pc_redirect, forwarding_override
  );

  modport slave (
    output id_SR1, id_SR2, id_DR, id_uses_sr1, id_uses_sr2, id_is_store, id_immsel,
    output ex_DR, ex_regwrite, ex_memread,
    output imem_read, imem_resp, dmem_req, dmem_resp, mem_br_taken,
    input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
    input  if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
    input  pc_redirect, forwarding_override
  );
endinterface

// File: rtl/hazard_controller.sv
// LC-3b 5-stage hazard controller: load-use stall, dmem wait with watchdog, branch flush.
// Optional stall/flush performance counters under HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned WAIT_W   = 8
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W    = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_controller_if.master hz,
  output logic                mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    ldu_stall_cnt,
  output logic [CNT_W-1:0]    dmem_stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    DWAIT = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [WAIT_W-1:0] wait_cnt;

  logic lu;
  logic dstall;
  logic istall;
  logic dstall_act;
  logic br_act;
  logic lu_act;
  logic ist_act;

  logic pc_load;
  logic if_id_load;
  logic id_ex_load;
  logic ex_mem_load;
  logic mem_wb_load;
  logic if_id_bubble;
  logic id_ex_bubble;
  logic ex_mem_bubble;
  logic mem_wb_bubble;
  logic pc_redirect;
  logic forwarding_override;

  // Raw hazard terms from the ID/EX operand fields and memory handshakes
  assign lu = hz.ex_memread & hz.ex_regwrite &
              ((hz.id_uses_sr1 & (hz.id_SR1 == hz.ex_DR)) |
               (hz.id_uses_sr2 & ~hz.id_immsel & (hz.id_SR2 == hz.ex_DR)) |
               (hz.id_is_store & (hz.id_DR == hz.ex_DR)));
  assign dstall = hz.dmem_req & ~hz.dmem_resp;
  assign istall = hz.imem_read & ~hz.imem_resp;

  // Per-state qualified events, priority dstall > branch > load-use > istall.
  // FLUSH holds only squashed bubbles downstream, so only istall is meaningful there.
  assign dstall_act = (state == DWAIT) ? ~hz.dmem_resp
                                       : ((state != FLUSH) & dstall);
  assign br_act     = (state != FLUSH) & hz.mem_br_taken & ~dstall_act;
  assign lu_act     = ((state == RUN) | (state == DWAIT)) & lu & ~dstall_act & ~br_act;
  assign ist_act    = istall & ~dstall_act & ~br_act & ~lu_act;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = RUN;
    if (dstall_act)  state_next = DWAIT;
    else if (br_act) state_next = FLUSH;
    else if (lu_act) state_next = LDUSE;
  end

  always_comb begin
    pc_load             = 1'b1;
    if_id_load          = 1'b1;
    id_ex_load          = 1'b1;
    ex_mem_load         = 1'b1;
    mem_wb_load         = 1'b1;
    if_id_bubble        = 1'b0;
    id_ex_bubble        = 1'b0;
    ex_mem_bubble       = 1'b0;
    mem_wb_bubble       = 1'b0;
    pc_redirect         = 1'b0;
    forwarding_override = (state != FLUSH);

    if (dstall_act) begin
      // Freeze everything; WB takes a bubble so nothing re-commits
      pc_load       = 1'b0;
      if_id_load    = 1'b0;
      id_ex_load    = 1'b0;
      ex_mem_load   = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (br_act) begin
      pc_redirect   = 1'b1;
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (lu_act) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (ist_act) begin
      pc_load      = 1'b0;
      if_id_bubble = 1'b1;
    end

    if (!rst_n) begin
      pc_load             = 1'b0;
      if_id_load          = 1'b0;
      id_ex_load          = 1'b0;
      ex_mem_load         = 1'b0;
      mem_wb_load         = 1'b0;
      if_id_bubble        = 1'b1;
      id_ex_bubble        = 1'b1;
      ex_mem_bubble       = 1'b1;
      mem_wb_bubble       = 1'b1;
      pc_redirect         = 1'b0;
      forwarding_override = 1'b0;
    end
  end

  assign hz.pc_load             = pc_load;
  assign hz.if_id_load          = if_id_load;
  assign hz.id_ex_load          = id_ex_load;
  assign hz.ex_mem_load         = ex_mem_load;
  assign hz.mem_wb_load         = mem_wb_load;
  assign hz.if_id_bubble        = if_id_bubble;
  assign hz.id_ex_bubble        = id_ex_bubble;
  assign hz.ex_mem_bubble       = ex_mem_bubble;
  assign hz.mem_wb_bubble       = mem_wb_bubble;
  assign hz.pc_redirect         = pc_redirect;
  assign hz.forwarding_override = forwarding_override;

  // dmem watchdog: counts stalled cycles, saturates, latches timeout until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (dstall_act) begin
        if (wait_cnt != WAIT_W'(WAIT_MAX)) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (wait_cnt == WAIT_W'(WAIT_MAX)) mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating occupancy counters; DWAIT counting includes the stall entry cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ldu_stall_cnt  <= '0;
      dmem_stall_cnt <= '0;
      flush_cnt      <= '0;
    end else begin
      if ((state == LDUSE) && !(&ldu_stall_cnt))
        ldu_stall_cnt <= ldu_stall_cnt + 1'b1;
      if ((dstall_act || (state == DWAIT)) && !(&dmem_stall_cnt))
        dmem_stall_cnt <= dmem_stall_cnt + 1'b1;
      if ((state == FLUSH) && !(&flush_cnt))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (default build, counters off).
module tb_hazard_controller;

  // {pc,if_id,id_ex,ex_mem,mem_wb loads, if_id,id_ex,ex_mem,mem_wb bubbles, redirect, fwd}
  localparam logic [10:0] RUN_ALL = 11'b11111_0000_0_1;
  localparam logic [10:0] RST_OUT = 11'b00000_1111_0_0;
  localparam logic [10:0] DSTALL  = 11'b00001_0001_0_1;
  localparam logic [10:0] BR      = 11'b11111_1110_1_1;
  localparam logic [10:0] LU      = 11'b00111_0100_0_1;
  localparam logic [10:0] IST     = 11'b01111_1000_0_1;
  localparam logic [10:0] FL_ALL  = 11'b11111_0000_0_0;
  localparam logic [10:0] FL_IST  = 11'b01111_1000_0_0;

  logic clk;
  logic rst_n;
  logic mem_timeout;
  logic [10:0] ctl;
  int total;
  int bad;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] ldu_stall_cnt;
  logic [15:0] dmem_stall_cnt;
  logic [15:0] flush_cnt;
`endif

  hazard_controller_if bus ();

  hazard_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hz          (bus),
    .mem_timeout (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .ldu_stall_cnt  (ldu_stall_cnt),
    .dmem_stall_cnt (dmem_stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  assign ctl = {bus.pc_load, bus.if_id_load, bus.id_ex_load, bus.ex_mem_load, bus.mem_wb_load,
                bus.if_id_bubble, bus.id_ex_bubble, bus.ex_mem_bubble, bus.mem_wb_bubble,
                bus.pc_redirect, bus.forwarding_override};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.id_SR1 = 3'd0;  bus.id_SR2 = 3'd0;  bus.id_DR = 3'd0;
    bus.id_uses_sr1 = 1'b0; bus.id_uses_sr2 = 1'b0;
    bus.id_is_store = 1'b0; bus.id_immsel = 1'b0;
    bus.ex_DR = 3'd0; bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0;
    bus.imem_read = 1'b0; bus.imem_resp = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_resp = 1'b0; bus.mem_br_taken = 1'b0;
  endtask

  // LDR R2 in EX
  task automatic load_in_ex();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_DR = 3'd2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    #1;
    total++; if (ctl !== RST_OUT) begin bad++; $display("FAIL reset_out ctl=%b exp=%b", ctl, RST_OUT); end
    @(negedge clk);
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
    rst_n = 1'b1;
    #1;
    total++; if (ctl !== RUN_ALL) begin bad++; $display("FAIL reset_release ctl=%b exp=%b", ctl, RUN_ALL); end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    load_in_ex(); bus.id_uses_sr1 = 1'b1; bus.id_SR1 = 3'd2;
    #1;
    total++; if (ctl !== LU) begin bad++; $display("FAIL lu_sr1 ctl=%b exp=%b", ctl, LU); end
    @(negedge clk);
    #1;  // LDUSE: the same match must not stall a second time
    total++; if (ctl !== RUN_ALL) begin bad++; $display("FAIL lu_one_cycle ctl=%b exp=%b", ctl, RUN_ALL); end
    @(negedge clk);
    idle(); #1;
    total++; if (ctl !== RUN_ALL) begin bad++; $display("FAIL lu_after ctl=%b exp=%b", ctl, RUN_ALL); end
    @(negedge clk);
    // immediate replaces SR2, so no dependency
    load_in_ex(); bus.id_uses_sr2 = 1'b1; bus.id_SR2 = 3'd2; bus.id_immsel = 1'b1;
    #1;
    total++; if (ctl !== RUN_ALL) begin bad++; $display("FAIL lu_imm_bypass ctl=%b exp=%b", ctl, RUN_ALL); end
    bus.id_immsel = 1'b0; #1;
    total++; if (ctl !== LU) begin bad++; $display("FAIL lu_sr2 ctl=%b exp=%b", ctl, LU); end
    @(negedge clk);
    idle(); @(negedge clk);
    load_in_ex(); bus.id_is_store = 1'b1; bus.id_DR = 3'd2; bus.id_SR1 = 3'd2;
    bus.ex_regwrite = 1'b0; #1;
    total++; if (ctl !== RUN_ALL) begin bad++; $display("FAIL lu_no_regwrite ctl=%b exp=%b", ctl, RUN_ALL); end
    bus.ex_regwrite = 1'b1; bus.imem_read = 1'b1; #1;
    total++; if (ctl !== LU) begin bad++; $display("FAIL lu_store_istall ctl=%b exp=%b", ctl, LU); end
    @(negedge clk);
    idle(); @(negedge clk);
  endtask

  task automatic test_istall();
    bus.imem_read = 1'b1; #1;
    total++; if (ctl !== IST) begin bad++; $display("FAIL istall_1 ctl=%b exp=%b", ctl, IST); end
    @(negedge clk); #1;
    total++; if (ctl !== IST) begin bad++; $display("FAIL istall_2 ctl=%b exp=%b", ctl, IST); end
    bus.imem_resp = 1'b1; #1;
    total++; if (ctl !== RUN_ALL) begin bad++; $display("FAIL istall_resp ctl=%b exp=%b", ctl, RUN_ALL); end
    @(negedge clk);
    idle(); @(negedge clk);
  endtask

  task automatic test_dmem_miss();
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctl !== DSTALL) begin bad++; $display("FAIL dmiss_cyc%0d ctl=%b exp=%b", i, ctl, DSTALL); end
      @(negedge clk);
    end
    // response cycle re-evaluates load-use
    bus.dmem_resp = 1'b1; load_in_ex(); bus.id_uses_sr1 = 1'b1; bus.id_SR1 = 3'd2; #1;
    total++; if (ctl !== LU) begin bad++; $display("FAIL dmiss_resp_lu ctl=%b exp=%b", ctl, LU); end
    @(negedge clk);
    idle(); #1;
    total++; if (ctl !== RUN_ALL) begin bad++; $display("FAIL dmiss_after ctl=%b exp=%b", ctl, RUN_ALL); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL dmiss_no_timeout got=%b exp=0", mem_timeout); end
    @(negedge clk);
  endtask

  task automatic test_branch();
    bus.mem_br_taken = 1'b1; #1;
    total++; if (ctl !== BR) begin bad++; $display("FAIL br_redirect ctl=%b exp=%b", ctl, BR); end
    @(negedge clk);
    load_in_ex(); bus.id_uses_sr1 = 1'b1; bus.id_SR1 = 3'd2; #1;
    total++; if (ctl !== FL_ALL) begin bad++; $display("FAIL br_flush ctl=%b exp=%b", ctl, FL_ALL); end
    @(negedge clk);
    idle(); #1;
    total++; if (ctl !== RUN_ALL) begin bad++; $display("FAIL br_after ctl=%b exp=%b", ctl, RUN_ALL); end
    bus.mem_br_taken = 1'b1; #1;
    @(negedge clk);
    idle(); bus.imem_read = 1'b1; #1;
    total++; if (ctl !== FL_IST) begin bad++; $display("FAIL br_flush_istall ctl=%b exp=%b", ctl, FL_IST); end
    @(negedge clk);
    idle(); @(negedge clk);
  endtask

  task automatic test_priority();
    bus.dmem_req = 1'b1; bus.mem_br_taken = 1'b1; #1;
    total++; if (ctl !== DSTALL) begin bad++; $display("FAIL prio_dstall_br ctl=%b exp=%b", ctl, DSTALL); end
    @(negedge clk);
    @(negedge clk); #1;
    total++; if (ctl !== DSTALL) begin bad++; $display("FAIL prio_wait_br ctl=%b exp=%b", ctl, DSTALL); end
    bus.dmem_resp = 1'b1; #1;
    total++; if (ctl !== BR) begin bad++; $display("FAIL prio_br_on_resp ctl=%b exp=%b", ctl, BR); end
    @(negedge clk);
    idle(); #1;
    total++; if (ctl !== FL_ALL) begin bad++; $display("FAIL prio_flush ctl=%b exp=%b", ctl, FL_ALL); end
    @(negedge clk);
    bus.dmem_req = 1'b1; load_in_ex(); bus.id_uses_sr1 = 1'b1; bus.id_SR1 = 3'd2; #1;
    total++; if (ctl !== DSTALL) begin bad++; $display("FAIL prio_dstall_lu ctl=%b exp=%b", ctl, DSTALL); end
    @(negedge clk);
    // reset in DWAIT: outputs forced immediately, state abandoned
    rst_n = 1'b0; #1;
    total++; if (ctl !== RST_OUT) begin bad++; $display("FAIL rst_in_dwait ctl=%b exp=%b", ctl, RST_OUT); end
    @(negedge clk); #1;
    total++; if (ctl !== RST_OUT) begin bad++; $display("FAIL rst_held ctl=%b exp=%b", ctl, RST_OUT); end
    rst_n = 1'b1; idle(); load_in_ex(); bus.id_uses_sr1 = 1'b1; bus.id_SR1 = 3'd2; #1;
    total++; if (ctl !== LU) begin bad++; $display("FAIL rst_back_to_run ctl=%b exp=%b", ctl, LU); end
    @(negedge clk);
    idle(); @(negedge clk);
  endtask

  task automatic test_watchdog();
    logic stall_ok;
    stall_ok = 1'b1;
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (ctl !== DSTALL) stall_ok = 1'b0;
      @(negedge clk);
      if (i == 254) begin
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL wd_early got=%b exp=0", mem_timeout); end
      end
    end
    total++; if (stall_ok !== 1'b1) begin bad++; $display("FAIL wd_stall_outputs got=%b exp=1", stall_ok); end
    total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL wd_set got=%b exp=1", mem_timeout); end
    bus.dmem_resp = 1'b1; #1;
    total++; if (ctl !== RUN_ALL) begin bad++; $display("FAIL wd_resp ctl=%b exp=%b", ctl, RUN_ALL); end
    @(negedge clk);
    idle(); @(negedge clk); @(negedge clk);
    total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b exp=1", mem_timeout); end
    rst_n = 1'b0; @(negedge clk);
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL wd_reset_clear got=%b exp=0", mem_timeout); end
    rst_n = 1'b1; @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_istall();
    test_dmem_miss();
    test_branch();
    test_priority();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
